gray_spi_receiver: RTL and testbench

GRAY_SPI_RECEIVER -- requirements
Module: gray_spi_receiver

---
 rtl/gray_spi_receiver_if.sv | 26 ++
 rtl/gray_spi_receiver.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_gray_spi_receiver.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/gray_spi_receiver_if.sv
// SPI + APB bundle for gray_spi_receiver: Gray transmitter drives the SPI side, a CPU master drives APB.
// master = upstream/CPU side, slave = receiver side; irq travels with the bus.
interface gray_spi_receiver_if;
    logic       sclk;
    logic       mosi;
    logic       cs;
    logic       psel;
    logic       penable;
    logic       pwrite;
    logic [2:0] paddr;
    logic [7:0] pwdata;
    logic [7:0] prdata;
    logic       pready;
    logic       pslverr;
    logic       irq;

    modport master (
        output sclk, mosi, cs, psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr, irq
    );

    modport slave (
        input  sclk, mosi, cs, psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr, irq
    );
endinterface

// File: rtl/gray_spi_receiver.sv
// Gray-coded SPI frame receiver with a decoded-word FIFO behind an APB register file.
// Latency: word enters FIFO 1 clk after the last sclk fall; APB answers 1 clk after setup. Backpressure: full FIFO drops and flags ovf.
module gray_spi_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_vld,
    output logic [WIDTH-1:0] head_dat,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             drop
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             pop_ok;
    logic             push_ok;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign empty    = (count == '0);
    assign full     = (count == FULL_CNT);
    assign head_dat = mem[rd_ptr];

    // A pop frees the slot in the same cycle, so push+pop succeeds even when full.
    assign pop_ok   = pop_vld & ~empty & ~flush;
    assign push_ok  = push_vld & ~flush & (~full | pop_ok);
    assign drop     = push_vld & ~flush & full & ~pop_ok;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop_ok) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// Top: SPI deserialiser + Gray decoder + FIFO + APB registers DATA(0) / STATUS(2) / CTRL(4).
// Latency: see file header. Backpressure: none toward SPI; overflow words are dropped and flagged.
module gray_spi_receiver #(
    parameter int NO_OF_SPI_BITS = 8,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic               clk,
    input  logic               rst,
    gray_spi_receiver_if.slave bus
);
    localparam int CNTW = (NO_OF_SPI_BITS > 1) ? $clog2(NO_OF_SPI_BITS) : 1;
    localparam int FCW  = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNTW-1:0] LAST_BIT = CNTW'(NO_OF_SPI_BITS - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_STATUS = 3'd2;
    localparam logic [2:0] ADDR_CTRL   = 3'd4;

    typedef struct packed {
        logic       busy;
        logic       frame_err;
        logic       ovf;
        logic       full;
        logic       empty;
        logic [2:0] count;
    } status_t;

    logic [1:0]                state;
    logic [CNTW-1:0]           bit_cnt;
    logic [NO_OF_SPI_BITS-1:0] shreg;
    logic                      sclk_d;
    logic                      sclk_fall;
    logic                      frame_end;
    logic                      frame_abort;

    logic                      push_vld;
    logic [NO_OF_SPI_BITS-1:0] push_dat;
    logic                      pop_vld;
    logic [NO_OF_SPI_BITS-1:0] fifo_head;
    logic [FCW-1:0]            fifo_count;
    logic                      fifo_empty;
    logic                      fifo_full;
    logic                      fifo_drop;

    logic [3:0]                ctrl;
    logic                      ovf;
    logic                      frame_err;
    status_t                   status;

    logic                      apb_setup;
    logic [7:0]                rsp_dat_nxt;
    logic                      rsp_err_nxt;
    logic [7:0]                rsp_dat;
    logic                      rsp_rdy;
    logic                      rsp_err;
    logic                      unused_wdata;

    assign sclk_fall   = sclk_d & ~bus.sclk;
    assign frame_end   = (state == SHIFT) & ~bus.cs & sclk_fall & (bit_cnt == '0);
    assign frame_abort = (state == SHIFT) & bus.cs;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_d <= 1'b0;
        end else begin
            sclk_d <= bus.sclk;
        end
    end

    // rx_enable only gates IDLE->SHIFT, so clearing it never truncates a frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            shreg    <= '0;
            push_vld <= 1'b0;
        end else begin
            push_vld <= frame_end;
            case (state)
                IDLE: begin
                    if (!bus.cs && ctrl[0]) begin
                        state   <= SHIFT;
                        bit_cnt <= LAST_BIT;
                    end
                end
                SHIFT: begin
                    if (bus.cs) begin
                        state <= IDLE;
                    end else if (sclk_fall) begin
                        shreg <= {shreg[NO_OF_SPI_BITS-2:0], bus.mosi};
                        if (bit_cnt == '0) begin
                            state <= DONE;
                        end else begin
                            bit_cnt <= bit_cnt - 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (bus.cs) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        logic acc;
        acc      = 1'b0;
        push_dat = '0;
        for (int i = NO_OF_SPI_BITS - 1; i >= 0; i--) begin
            acc         = acc ^ shreg[i];
            push_dat[i] = acc;
        end
    end

    gray_spi_fifo #(
        .WIDTH (NO_OF_SPI_BITS),
        .DEPTH (FIFO_DEPTH),
        .CW    (FCW)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (ctrl[2]),
        .push_vld (push_vld),
        .push_dat (push_dat),
        .pop_vld  (pop_vld),
        .head_dat (fifo_head),
        .count    (fifo_count),
        .empty    (fifo_empty),
        .full     (fifo_full),
        .drop     (fifo_drop)
    );

    // Sticky flags: a new event in the clear cycle wins so it is never lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf       <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            ovf       <= (ovf & ~ctrl[1]) | fifo_drop;
            frame_err <= (frame_err & ~ctrl[1]) | frame_abort;
        end
    end

    assign apb_setup    = bus.psel & ~bus.penable;
    assign pop_vld      = apb_setup & ~bus.pwrite & (bus.paddr == ADDR_DATA) & ~fifo_empty;
    assign unused_wdata = ^bus.pwdata[7:4];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl <= 4'h0;
        end else if (apb_setup && bus.pwrite && (bus.paddr == ADDR_CTRL)) begin
            ctrl <= bus.pwdata[3:0];
        end else begin
            ctrl[2:1] <= 2'b00;
        end
    end

    always_comb begin
        status.busy      = (state != IDLE);
        status.frame_err = frame_err;
        status.ovf       = ovf;
        status.full      = fifo_full;
        status.empty     = fifo_empty;
        status.count     = 3'(fifo_count);
    end

    always_comb begin
        rsp_dat_nxt = 8'h00;
        rsp_err_nxt = 1'b0;
        case (bus.paddr)
            ADDR_DATA: begin
                if (bus.pwrite || fifo_empty) begin
                    rsp_err_nxt = 1'b1;
                end else begin
                    rsp_dat_nxt = 8'(fifo_head);
                end
            end
            ADDR_STATUS: begin
                if (bus.pwrite) begin
                    rsp_err_nxt = 1'b1;
                end else begin
                    rsp_dat_nxt = status;
                end
            end
            ADDR_CTRL: begin
                if (!bus.pwrite) begin
                    rsp_dat_nxt = {4'h0, ctrl};
                end
            end
            default: rsp_err_nxt = 1'b1;
        endcase
    end

    // Response lives for exactly the cycle after setup; outside it every output is zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_rdy <= 1'b0;
            rsp_err <= 1'b0;
            rsp_dat <= 8'h00;
        end else begin
            rsp_rdy <= apb_setup;
            rsp_err <= apb_setup & rsp_err_nxt;
            rsp_dat <= apb_setup ? rsp_dat_nxt : 8'h00;
        end
    end

    assign bus.pready  = rsp_rdy;
    assign bus.pslverr = rsp_err;
    assign bus.prdata  = rsp_dat;
    assign bus.irq     = ~fifo_empty & ctrl[3];
endmodule

// File: tb/tb_gray_spi_receiver.sv
// Bench for gray_spi_receiver: decode table, directed corner sequences, then randomized traffic vs a queue model.
module tb_gray_spi_receiver;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    gray_spi_receiver_if bus();

    gray_spi_receiver #(
        .NO_OF_SPI_BITS (8),
        .FIFO_DEPTH     (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] gray;
        logic [7:0] bin;
    } vec_t;

    vec_t       tbl [8];
    logic [7:0] q [$];
    logic [7:0] rdat;
    logic       rerr;
    logic [7:0] g;
    logic [7:0] ctrl_v;
    logic       ovf_m;
    int         op;

    // Reference: the binary word whose Gray code (b ^ b>>1) equals g, found by search.
    function automatic logic [7:0] g2b(input logic [7:0] gv);
        for (int v = 0; v < 256; v++) begin
            if (8'(v ^ (v >> 1)) == gv) return 8'(v);
        end
        return 8'h00;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%02h required 0x%02h", name, act, exp);
        end
    endtask

    task automatic apb(input logic wr, input logic [2:0] addr, input logic [7:0] wdata,
                       output logic [7:0] rd, output logic err);
        @(negedge clk);
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr; bus.paddr = addr; bus.pwdata = wdata;
        @(negedge clk);
        bus.penable = 1'b1;
        check("pready_hi", {7'b0, bus.pready}, 8'h01);
        rd  = bus.prdata;
        err = bus.pslverr;
        @(negedge clk);
        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
        check("pready_pslverr_lo", {6'b0, bus.pready, bus.pslverr}, 8'h00);
    endtask

    task automatic wr(input logic [2:0] addr, input logic [7:0] data, input logic exp_err);
        logic [7:0] d;
        logic       e;
        apb(1'b1, addr, data, d, e);
        check("wr_pslverr", {7'b0, e}, {7'b0, exp_err});
    endtask

    task automatic rd(input string name, input logic [2:0] addr, input logic [7:0] exp, input logic exp_err);
        logic [7:0] d;
        logic       e;
        apb(1'b0, addr, 8'h00, d, e);
        check(name, d, exp);
        check({name, "_pslverr"}, {7'b0, e}, {7'b0, exp_err});
    endtask

    // Ends on the negedge where sclk falls; the DUT samples at the following posedge.
    task automatic spi_bit(input logic b);
        @(negedge clk);
        bus.mosi = b; bus.sclk = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.sclk = 1'b0;
    endtask

    task automatic spi_bits(input logic [7:0] gv, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) spi_bit(gv[i]);
    endtask

    task automatic cs_low();
        @(negedge clk);
        bus.cs = 1'b0;
        @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (3) @(negedge clk);
        bus.cs = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic spi_frame(input logic [7:0] gv);
        cs_low();
        spi_bits(gv, 7, 0);
        cs_high();
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        rst = 1'b1;
        bus.sclk = 1'b0; bus.mosi = 1'b0; bus.cs = 1'b1;
        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = 3'd0; bus.pwdata = 8'h00;

        tbl[0] = '{8'h0F, 8'h0A}; tbl[1] = '{8'h80, 8'hFF};
        tbl[2] = '{8'h00, 8'h00}; tbl[3] = '{8'hC0, 8'h80};
        tbl[4] = '{8'h01, 8'h01}; tbl[5] = '{8'hFF, 8'hAA};
        tbl[6] = '{8'h55, 8'h66}; tbl[7] = '{8'h03, 8'h02};

        repeat (3) @(negedge clk);
        check("rst_prdata", bus.prdata, 8'h00);
        check("rst_pready", {7'b0, bus.pready}, 8'h00);
        check("rst_pslverr", {7'b0, bus.pslverr}, 8'h00);
        check("rst_irq", {7'b0, bus.irq}, 8'h00);
        rst = 1'b0;
        rd("rst_status", 3'd2, 8'h08, 1'b0);
        rd("rst_ctrl", 3'd4, 8'h00, 1'b0);

        wr(3'd4, 8'h01, 1'b0);
        for (int i = 0; i < 8; i++) begin
            spi_frame(tbl[i].gray);
            rd("tbl_data", 3'd0, tbl[i].bin, 1'b0);
        end

        spi_frame(8'h0F);
        rd("basic_status1", 3'd2, 8'h01, 1'b0);
        rd("basic_data", 3'd0, 8'h0A, 1'b0);
        rd("basic_status2", 3'd2, 8'h08, 1'b0);

        spi_frame(8'h80); spi_frame(8'h00); spi_frame(8'hC0); spi_frame(8'h01);
        rd("order_status_full", 3'd2, 8'h14, 1'b0);
        rd("order_d0", 3'd0, 8'hFF, 1'b0);
        rd("order_d1", 3'd0, 8'h00, 1'b0);
        rd("order_d2", 3'd0, 8'h80, 1'b0);
        rd("order_d3", 3'd0, 8'h01, 1'b0);

        // Push of the 5th word lands in the same clk as a DATA pop on a full FIFO.
        spi_frame(8'h11); spi_frame(8'h22); spi_frame(8'h33); spi_frame(8'h44);
        cs_low();
        spi_bits(8'h55, 7, 0);
        rd("pushpop_data", 3'd0, g2b(8'h11), 1'b0);
        cs_high();
        rd("pushpop_status", 3'd2, 8'h14, 1'b0);
        rd("pushpop_d1", 3'd0, g2b(8'h22), 1'b0);
        rd("pushpop_d2", 3'd0, g2b(8'h33), 1'b0);
        rd("pushpop_d3", 3'd0, g2b(8'h44), 1'b0);
        rd("pushpop_d4", 3'd0, g2b(8'h55), 1'b0);

        for (int i = 1; i <= 5; i++) spi_frame(8'(i));
        rd("ovf_status", 3'd2, 8'h34, 1'b0);
        wr(3'd4, 8'h03, 1'b0);
        rd("clr_ctrl", 3'd4, 8'h01, 1'b0);
        rd("clr_status", 3'd2, 8'h14, 1'b0);
        for (int i = 1; i <= 4; i++) rd("ovf_keep", 3'd0, g2b(8'(i)), 1'b0);
        rd("ovf_drained", 3'd2, 8'h08, 1'b0);

        cs_low();
        spi_bits(8'h0F, 7, 5);
        cs_high();
        rd("abort_status", 3'd2, 8'h48, 1'b0);
        spi_frame(8'h0F);
        rd("abort_next", 3'd0, 8'h0A, 1'b0);
        wr(3'd4, 8'h03, 1'b0);
        rd("abort_clr", 3'd2, 8'h08, 1'b0);

        rd("empty_data", 3'd0, 8'h00, 1'b1);
        wr(3'd2, 8'hFF, 1'b1);
        wr(3'd0, 8'hFF, 1'b1);
        rd("addr6", 3'd6, 8'h00, 1'b1);
        rd("err_nochange", 3'd2, 8'h08, 1'b0);

        wr(3'd4, 8'h09, 1'b0);
        spi_frame(8'h3C);
        check("irq_set", {7'b0, bus.irq}, 8'h01);
        wr(3'd4, 8'h0D, 1'b0);
        check("irq_flush", {7'b0, bus.irq}, 8'h00);
        rd("flush_status", 3'd2, 8'h08, 1'b0);
        rd("flush_ctrl", 3'd4, 8'h09, 1'b0);

        wr(3'd4, 8'h01, 1'b0);
        cs_low();
        spi_bits(8'hA5, 7, 4);
        rd("busy_status", 3'd2, 8'h88, 1'b0);
        wr(3'd4, 8'h00, 1'b0);
        spi_bits(8'hA5, 3, 0);
        cs_high();
        rd("rxdis_midframe", 3'd0, g2b(8'hA5), 1'b0);
        spi_frame(8'h5A);
        rd("rxdis_blocked", 3'd2, 8'h08, 1'b0);

        wr(3'd4, 8'h09, 1'b0);
        spi_frame(8'h12);
        cs_low();
        spi_bits(8'h34, 7, 4);
        @(negedge clk);
        rst = 1'b1; bus.cs = 1'b1;
        repeat (2) @(negedge clk);
        check("mrst_irq", {7'b0, bus.irq}, 8'h00);
        rst = 1'b0;
        rd("mrst_status", 3'd2, 8'h08, 1'b0);
        rd("mrst_ctrl", 3'd4, 8'h00, 1'b0);

        wr(3'd4, 8'h07, 1'b0);
        ctrl_v = 8'h01;
        ovf_m  = 1'b0;
        q.delete();
        for (int it = 0; it < 60; it++) begin
            op = $urandom_range(0, 6);
            if (op <= 2) begin
                g = 8'($urandom);
                spi_frame(g);
                if (q.size() == 4) ovf_m = 1'b1;
                else q.push_back(g2b(g));
            end else if (op == 3) begin
                if (q.size() == 0) rd("rnd_data_empty", 3'd0, 8'h00, 1'b1);
                else rd("rnd_data", 3'd0, q.pop_front(), 1'b0);
            end else if (op == 4) begin
                rd("rnd_status", 3'd2,
                   {2'b00, ovf_m, q.size() == 4, q.size() == 0, 3'(q.size())}, 1'b0);
            end else if (op == 5) begin
                ctrl_v = ctrl_v ^ 8'h08;
                wr(3'd4, ctrl_v, 1'b0);
            end else begin
                wr(3'd4, ctrl_v | 8'h02, 1'b0);
                ovf_m = 1'b0;
            end
            check("rnd_irq", {7'b0, bus.irq}, {7'b0, ctrl_v[3] && (q.size() != 0)});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
